// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed hex 7-segment driver with per-slot anode blanking,
// frame-consistent shadow capture and registered outputs.
module seg7_mux_driver #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  // Active-high g..a patterns, digit 0 in the low 7 bits.
  localparam logic [111:0] HEX = {
    7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
    7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111};
  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW != 0 ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [6:0]              seg_q, seg_d, seg_ah;
  logic [NUM_DIGITS-1:0]   an_q, an_d, an_ah;
  logic                    tick_q, tick_d;
  logic                    last, load, on;
  logic [3:0]              cur_dig;

  always_comb begin
    last    = cnt_q == CW'(REFRESH_DIV - 1);
    load    = cnt_q == '0 && idx_q == '0;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    idx_d   = !last ? idx_q : (idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1);
    dig_d   = load ? digits_in : dig_q;
    blank_d = load ? blank_in : blank_q;
    cur_dig = dig_q[{idx_q, 2'b00} +: 4];
    // Slot start stays dark so the previous digit's anode can fully turn off.
    on      = cnt_q >= CW'(BLANK_CYCLES) && !blank_q[idx_q];
    seg_ah  = on ? HEX[7'(cur_dig) * 7'd7 +: 7] : 7'h00;
    an_ah   = on ? NUM_DIGITS'(1) << idx_q : {NUM_DIGITS{1'b0}};
    seg_d   = ACTIVE_LOW != 0 ? ~seg_ah : seg_ah;
    an_d    = ACTIVE_LOW != 0 ? ~an_ah : an_ah;
    tick_d  = load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      dig_q   <= '0;
      blank_q <= {NUM_DIGITS{1'b1}};
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      blank_q <= blank_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb_seg7_mux_driver: directed bench with a queue scoreboard fed by a cycle-position model.
module tb_seg7_mux_driver;
  localparam int ND = 2, RD = 8, BC = 2;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       tick;
  } out_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] digits_in;
  logic [1:0] blank_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  logic [6:0] hex_ah [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                              7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                              7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                              7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  out_t       q[$];
  int         n_chk = 0, n_pass = 0, n_fail = 0;
  int         m_t, cycle = 0, ticks = 0, last_tick = -1;
  logic [7:0] m_dig;
  logic [1:0] m_blk;

  seg7_mux_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .blank_in(blank_in),
    .seg(seg), .an(an), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0;
    m_dig = 8'h00;
    m_blk = 2'b11;
    ticks = 0;
    last_tick = -1;
  endtask

  // Predict the outputs the next edge will register, then advance and compare.
  task automatic cyc();
    out_t e, g;
    int   cnt, idx;
    logic on;
    cnt = m_t % RD;
    idx = (m_t / RD) % ND;
    on = cnt >= BC && !m_blk[idx];
    e.tick = (m_t % (RD * ND)) == 0;
    e.an = on ? ~(2'b01 << idx) : 2'b11;
    e.seg = on ? ~hex_ah[m_dig[idx*4 +: 4]] : 7'h7f;
    q.push_back(e);
    if (e.tick) begin
      m_dig = digits_in;
      m_blk = blank_in;
    end
    m_t++;
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("seg", seg, g.seg);
    chk("an", an, g.an);
    chk("tick", frame_tick, g.tick);
    if (frame_tick === 1'b1) begin
      ticks++;
      if (last_tick >= 0) chk("tick_gap", cycle - last_tick, RD * ND);
      last_tick = cycle;
    end
    cycle++;
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_seg"}, seg, 7'h7f);
    chk({tag, "_an"}, an, 2'b11);
    chk({tag, "_tick"}, frame_tick, 1'b0);
  endtask

  initial begin
    int p;
    reset = 1'b1;
    digits_in = 8'($urandom);
    blank_in = 2'($urandom);
    #2;
    chk_off("rst_pre_edge");
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_off("rst_hold");
      digits_in = 8'($urandom);
      blank_in = 2'($urandom);
    end
    @(negedge clk);
    reset = 1'b0;
    digits_in = 8'h3A;
    blank_in = 2'b00;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      cyc();
      p = i % 8;
      chk("f1_an", an, p < 2 ? 2'b11 : (i < 8 ? 2'b10 : 2'b01));
      chk("f1_seg", seg, p < 2 ? 7'h7f : (i < 8 ? 7'b0001000 : 7'b0110000));
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 4) digits_in = 8'h5F;
      cyc();
      if (i >= 10) chk("f2_hold", seg, 7'b0110000);
    end
    for (int i = 0; i < 16; i++) begin
      if (i == 8) blank_in = 2'b10;
      cyc();
      if (i % 8 >= 2) chk("f3_new", seg, i < 8 ? 7'b0001110 : 7'b0010010);
    end
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i >= 8) begin
        chk("f4_blank_an", an, 2'b11);
        chk("f4_blank_seg", seg, 7'h7f);
      end else if (i >= 2) begin
        chk("f4_d0_an", an, 2'b10);
        chk("f4_d0_seg", seg, 7'b0001110);
      end
    end
    chk("tick_count", ticks, 4);
    blank_in = 2'b00;
    for (int i = 0; i < 13; i++) cyc();
    chk("pre_rst_an", an, 2'b01);
    chk("pre_rst_seg", seg, 7'b0010010);
    #2;
    reset = 1'b1;
    #1;
    chk_off("rst_async");
    @(posedge clk);
    #1;
    chk_off("rst_mid");
    digits_in = 8'($urandom);
    @(negedge clk);
    reset = 1'b0;
    digits_in = 8'h5F;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (i == 0) chk("rst_first_tick", frame_tick, 1'b1);
      if (i % 8 >= 2 && i < 8) chk("rst_slot0", an, 2'b10);
    end
    chk("rst_ticks", ticks, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
